fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Round-robin arbiter that shares the single write port of the 16x8 synchronous FIFO between NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- A granted producer may push up to MAX_BURST consecutive words before the grant rotates.
- The block sits directly in front of the FIFO: it drives the FIFO's wr_en and din and watches the FIFO's almost-full flag.

Parameters:
- NUM_REQ, 4: number of producers (2..8).
- WIDTH, 8: data word width; must match the FIFO.
- MAX_BURST, 4: maximum accepted words per grant (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-low; clears all state immediately.
- req_valid  in  NUM_REQ  per-producer data valid.
- req_data  in  NUM_REQ*WIDTH  producer i word at [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  per-producer accept, combinational.
- grant  out  NUM_REQ  one-hot current owner, registered; all zero when idle.
- fifo_afull  in  1  FIFO almost-full; must be asserted whenever 2 or fewer entries are free.
- fifo_wr_en  out  1  FIFO write strobe, registered.
- fifo_din  out  WIDTH  FIFO write data, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=0, rr_ptr=0, burst_cnt=0.
  - fifo_wr_en=0, fifo_din=0, req_ready=0.
  - A write already registered in fifo_wr_en is dropped; a reset in mid-burst discards the burst with no partial recovery.
- Transfer: occurs on producer i in a cycle where req_valid[i]=1 and req_ready[i]=1.
- Write path:
  - The cycle after a transfer, fifo_wr_en=1 and fifo_din holds the accepted word.
  - Otherwise fifo_wr_en=0 and fifo_din holds its last value.
  - Latency from transfer to FIFO write strobe is 1 cycle.
- State machine, 2 states:
  - IDLE:
    - req_ready=0.
    - If any req_valid is set: pick the first valid index searching upward from rr_ptr with wrap-around. Set grant to that one-hot index, burst_cnt=0, next state BUSY.
    - If none are valid: stay in IDLE.
    - Arbitration costs exactly 1 idle cycle per grant.
  - BUSY (owner g):
    - req_ready[g] = !fifo_afull; all other ready bits are 0.
    - Transfer with burst_cnt==MAX_BURST-1: release.
    - Transfer otherwise: burst_cnt+1, stay in BUSY.
    - req_valid[g]=0: release the same cycle, with no transfer.
    - fifo_afull=1 with req_valid[g]=1: hold. No transfer, burst_cnt unchanged, grant kept.
  - Release: grant=0, rr_ptr=(g+1) mod NUM_REQ, next state IDLE.
- Fairness:
  - The most recent owner has lowest priority at the next arbitration.
  - A continuously valid producer waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles for a grant, excluding almost-full stall cycles.
- Widths:
  - burst_cnt is 4 bits.
  - rr_ptr is ceil(log2(NUM_REQ)) bits; wrap from NUM_REQ-1 to 0 is explicit, including non-power-of-2 NUM_REQ.
- Invariants:
  - Non-granted producers never see ready; their data is never sampled.
  - grant is always zero or one-hot.
  - At most one transfer per cycle.
  - Word order within a producer is preserved.
- Back-pressure margin: a 2-entry almost-full margin absorbs the registered write and the FIFO's registered full flag. The arbiter never writes a full FIFO.

Test Plan:
- Single producer: req_valid=0001, data 0x10..0x17, afull=0 -> bursts 0x10-0x13 then 0x14-0x17, one IDLE cycle between them. fifo_din order is 0x10..0x17, and fifo_wr_en lags each ready&valid by 1 cycle.
- All four producers valid, MAX_BURST=4, producer i sends 0xi0.. -> grant order 0001,0010,0100,1000,0001. Each burst is 4 words, and each FIFO write sequence is contiguous per owner.
- Stall: owner 0 mid-burst (burst_cnt=2), assert fifo_afull for 5 cycles -> req_ready[0]=0 and no fifo_wr_en for those 5 cycles. Grant holds; on afull deassertion the remaining 2 words are written and the grant rotates.
- Early drop: owner 2 deasserts req_valid after 1 word -> release in that cycle, rr_ptr=3. A pending producer 3 is granted next, ahead of 0 and 1.
- Async reset mid-burst: pulse rst low between clock edges while owner 1 is in BUSY -> grant, req_ready, fifo_wr_en go to 0 immediately. After release with req_valid=0011, producer 0 is granted first.
- Wrap check with NUM_REQ=3: only producer 2 valid, then producers 0 and 2 valid -> after producer 2 releases, producer 0 is granted (rr_ptr wraps 2->0).

Source files
------------

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arb
// Brief   : Round-robin, burst-limited arbiter sharing one FIFO write port
//           among NUM_REQ valid/ready producers; honours FIFO almost-full.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_wr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       grant,
    input  logic                     fifo_afull,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_din
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0]       c_IDLE    = 1'b0;
    localparam logic [0:0]       c_BUSY    = 1'b1;
    localparam logic [3:0]       c_LAST    = 4'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] c_PTR_MAX = PTR_W'(NUM_REQ - 1);

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [3:0]         r_burst_cnt;
    logic               r_wr_en;
    logic [WIDTH-1:0]   r_din;

    logic [0:0]         w_state_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [PTR_W-1:0]   w_rr_ptr_nxt;
    logic [3:0]         w_burst_cnt_nxt;
    logic [PTR_W-1:0]   w_owner;
    logic [PTR_W-1:0]   w_pick;
    logic [PTR_W-1:0]   w_cand;
    logic               w_pick_found;
    logic               w_owner_valid;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_ready;
    logic [WIDTH-1:0]   w_owner_data;

    // Search upward from rr_ptr; the wrap is explicit so non-power-of-2
    // producer counts never index past NUM_REQ-1.
    always_comb begin
        w_pick       = r_rr_ptr;
        w_pick_found = 1'b0;
        w_cand       = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_pick_found && req_valid[w_cand]) begin
                w_pick       = w_cand;
                w_pick_found = 1'b1;
            end
            w_cand = (w_cand == c_PTR_MAX) ? '0 : w_cand + PTR_W'(1);
        end
    end

    always_comb begin
        w_owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) w_owner = PTR_W'(i);
        end
    end

    assign w_owner_valid = |(req_valid & r_grant);
    assign w_ready       = (r_state == c_BUSY && !fifo_afull) ? r_grant : '0;
    assign w_xfer        = |(req_valid & w_ready);
    assign w_owner_data  = req_data[w_owner*WIDTH +: WIDTH];

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_pick_found) begin
                    w_grant_nxt     = NUM_REQ'(1) << w_pick;
                    w_burst_cnt_nxt = '0;
                    w_state_nxt     = c_BUSY;
                end
            end
            c_BUSY: begin
                // A dropped valid releases immediately; a stalled owner keeps its grant.
                if (!w_owner_valid || (w_xfer && r_burst_cnt == c_LAST)) begin
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = (w_owner == c_PTR_MAX) ? '0 : w_owner + PTR_W'(1);
                    w_state_nxt  = c_IDLE;
                end else if (w_xfer) begin
                    w_burst_cnt_nxt = r_burst_cnt + 4'(1);
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_wr_en     <= 1'b0;
            r_din       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_wr_en     <= w_xfer;
            if (w_xfer) r_din <= w_owner_data;
        end
    end

    assign req_ready  = w_ready;
    assign grant      = r_grant;
    assign fifo_wr_en = r_wr_en;
    assign fifo_din   = r_din;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_wr_arb
// Brief   : Scoreboard bench for fifo_wr_arb (4-producer main instance plus a
//           3-producer instance for pointer wrap).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        fifo_afull;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;

    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  r3;
    logic [2:0]  g3;
    logic        we3;
    logic [7:0]  din3;

    int total = 0;
    int bad   = 0;

    logic [7:0] pq[4][$];
    bit         en[4];
    int         acc[4];
    bit         hs_last = 1'b0;
    logic [7:0] exp_w[$];
    logic [3:0] exp_g[$];
    logic [3:0] gprev = '0;

    always #5 clk = ~clk;

    fifo_wr_arb #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant(grant), .fifo_afull(fifo_afull),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din)
    );

    fifo_wr_arb #(.NUM_REQ(3), .WIDTH(8), .MAX_BURST(4)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3),
        .req_ready(r3), .grant(g3), .fifo_afull(1'b0),
        .fifo_wr_en(we3), .fifo_din(din3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = en[i] && (pq[i].size() > 0);
            req_data[i*8 +: 8]  = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
        end
    endtask

    // Producer model: pops its head word on each accepted handshake.
    initial begin
        forever begin
            bit hs;
            @(posedge clk);
            hs = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    void'(pq[i].pop_front());
                    acc[i]++;
                    hs = 1'b1;
                end
            end
            hs_last = hs;
            #1;
            drive();
        end
    end

    // Monitor: FIFO write data, grant sequence and per-cycle invariants.
    initial begin
        forever begin
            @(negedge clk);
            check("wr_en_latency", {31'd0, fifo_wr_en}, {31'd0, hs_last});
            check("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
            check("ready_in_grant", {28'd0, req_ready & ~grant}, 32'd0);
            if (fifo_wr_en) begin
                if (exp_w.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got=%0h want=none", fifo_din);
                end else begin
                    check("fifo_din", {24'd0, fifo_din}, {24'd0, exp_w.pop_front()});
                end
            end
            if (grant !== gprev && grant !== 4'd0) begin
                if (exp_g.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got=%0h want=none", grant);
                end else begin
                    check("grant_seq", {28'd0, grant}, {28'd0, exp_g.pop_front()});
                end
            end
            gprev = grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en[i]  = 1'b0;
            acc[i] = 0;
            pq[i].delete();
        end
        exp_w.delete();
        exp_g.delete();
        drive();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        bit busy = 1'b1;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
            busy = (exp_w.size() != 0) || (grant !== 4'd0);
            for (int i = 0; i < 4; i++) if (en[i] && pq[i].size() > 0) busy = 1'b1;
        end
        repeat (3) @(negedge clk);
        check({name, "_words_left"}, exp_w.size(), 32'd0);
        check({name, "_grants_left"}, exp_g.size(), 32'd0);
    endtask

    task automatic wait_acc(input int idx, input int cnt);
        int n = 0;
        while (acc[idx] < cnt && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("acc_reached", acc[idx], cnt);
    endtask

    initial begin
        rst        = 1'b0;
        fifo_afull = 1'b0;
        v3         = '0;
        d3         = 24'h332211;
        for (int i = 0; i < 4; i++) en[i] = 1'b0;
        drive();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("rst_din", {24'd0, fifo_din}, 32'd0);
        check("rst_grant3", {29'd0, g3}, 32'd0);
        rst = 1'b1;

        // Single producer: two 4-word bursts
        do_reset();
        for (int k = 0; k < 8; k++) begin
            pq[0].push_back(8'(8'h10 + k));
            exp_w.push_back(8'(8'h10 + k));
        end
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b0001);
        en[0] = 1'b1;
        drive();
        drain("single");

        // All four producers, two rounds of round-robin
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) pq[i].push_back(8'(i * 16 + k));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) begin
                exp_g.push_back(4'(1 << i));
                for (int k = 0; k < 4; k++) exp_w.push_back(8'(i * 16 + r * 4 + k));
            end
        for (int i = 0; i < 4; i++) en[i] = 1'b1;
        drive();
        drain("all4");

        // Almost-full stall at burst_cnt=2
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pq[0].push_back(8'(8'h40 + k));
            exp_w.push_back(8'(8'h40 + k));
        end
        pq[1].push_back(8'h50);
        exp_w.push_back(8'h50);
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b0010);
        en[0] = 1'b1;
        en[1] = 1'b1;
        drive();
        wait_acc(0, 2);
        fifo_afull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_ready", {28'd0, req_ready}, 32'd0);
            check("stall_grant", {28'd0, grant}, 32'd1);
        end
        @(posedge clk);
        #2;
        fifo_afull = 1'b0;
        drain("stall");

        // Early drop by owner 2; producer 3 wins over 0 and 1
        do_reset();
        pq[2].push_back(8'h60);
        pq[3].push_back(8'h70);
        pq[3].push_back(8'h71);
        exp_w = '{8'h60, 8'h70, 8'h71, 8'h80, 8'h90};
        exp_g = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        en[2] = 1'b1;
        en[3] = 1'b1;
        drive();
        begin
            int n = 0;
            while (grant !== 4'b0100 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        pq[0].push_back(8'h80);
        pq[1].push_back(8'h90);
        en[0] = 1'b1;
        en[1] = 1'b1;
        drive();
        drain("drop");

        // Asynchronous reset in the middle of producer 1's burst
        do_reset();
        for (int k = 0; k < 8; k++) pq[1].push_back(8'(8'hA0 + k));
        pq[0].push_back(8'hB0);
        exp_w = '{8'hA0, 8'hB0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        exp_g = '{4'b0010, 4'b0001, 4'b0010, 4'b0010};
        en[1] = 1'b1;
        drive();
        wait_acc(1, 1);
        @(negedge clk);
        #1;
        rst   = 1'b0;
        en[0] = 1'b1;
        drive();
        #1;
        check("arst_grant", {28'd0, grant}, 32'd0);
        check("arst_ready", {28'd0, req_ready}, 32'd0);
        check("arst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        #1;
        rst = 1'b1;
        drain("arst");

        // Pointer wrap with three producers
        @(negedge clk);
        v3 = 3'b100;
        begin
            int n = 0;
            while (g3 !== 3'b100 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("wrap_first", {29'd0, g3}, 32'd4);
            v3 = 3'b101;
            n  = 0;
            while (g3 === 3'b100 && n < 40) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            while (g3 === 3'b000 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("wrap_next", {29'd0, g3}, 32'd1);
        end
        v3 = 3'b000;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
